// File: rtl/dm_port_arbiter_if.sv
// dm_port_arbiter_if: CPU/DMA request ports, memory command port and
// pipeline enable for the shared data-memory arbiter.
// slave  : arbiter side (accepts requests, issues memory commands).
// master : environment side (requesters and memory).
interface dm_port_arbiter_if #(
    parameter int AW = 7
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_done;
    logic [31:0]   cpu_rdata;
    logic          en;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [31:0]   dma_wdata;
    logic          dma_done;
    logic [31:0]   dma_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_done, cpu_rdata, en,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_done, dma_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, err,
        input  mem_ready, mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_done, cpu_rdata, en,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_done, dma_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, err,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: round-robin arbiter between the MEM-stage CPU port and a
// DMA/loader port for the shared data memory. One access in flight at a time;
// the CPU pipeline is stalled (en=0) while its access is pending.
// Optional feature: define DMARB_TIMEOUT_EN to abort accesses that see no
// mem_ready within TIMEOUT cycles (done pulses with err=1, rdata=0).
module dm_port_arbiter #(
    parameter int AW      = 7,
    parameter int TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst,
    dm_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, CPU_ACC = 2'd1, DMA_ACC = 2'd2} state_t;

    state_t        state_q, state_d;
    logic          last_dma_q, last_dma_d;   // 1: DMA was granted last
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          cpu_done_q, cpu_done_d;
    logic          dma_done_q, dma_done_d;
    logic          err_q, err_d;
    logic [31:0]   cpu_rdata_q, cpu_rdata_d;
    logic [31:0]   dma_rdata_q, dma_rdata_d;

    logic          cpu_elig, dma_elig, gnt_cpu, gnt_dma, expire;
    logic [31:0]   acc_rdata;

    // A requester whose done is showing still has its req high this cycle;
    // it must not be re-granted on the strength of that stale level.
    assign cpu_elig  = bus.cpu_req & ~cpu_done_q;
    assign dma_elig  = bus.dma_req & ~dma_done_q;
    assign gnt_cpu   = cpu_elig & (~dma_elig | last_dma_q);
    assign gnt_dma   = dma_elig & ~gnt_cpu;
    assign acc_rdata = mem_we_q ? 32'd0 : bus.mem_rdata;

`ifdef DMARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry is the edge at which the wait count would reach TIMEOUT-1.
    assign expire = ~bus.mem_ready && (cnt_q == CW'(TIMEOUT - 2));

    // Wait-cycle counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    // Next-state: arbitration in IDLE, completion/abort in the access states.
    always_comb begin
        state_d     = state_q;
        last_dma_d  = last_dma_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_done_d  = 1'b0;
        dma_done_d  = 1'b0;
        err_d       = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
`ifdef DMARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_cpu) begin
                    state_d     = CPU_ACC;
                    last_dma_d  = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.cpu_we;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                end else if (gnt_dma) begin
                    state_d     = DMA_ACC;
                    last_dma_d  = 1'b1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dma_we;
                    mem_addr_d  = bus.dma_addr;
                    mem_wdata_d = bus.dma_wdata;
                end
`ifdef DMARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            CPU_ACC, DMA_ACC: begin
                // mem_ready wins over a coincident expiry.
                if (bus.mem_ready || expire) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    err_d     = ~bus.mem_ready;
                    if (state_q == CPU_ACC) begin
                        cpu_done_d  = 1'b1;
                        cpu_rdata_d = bus.mem_ready ? acc_rdata : 32'd0;
                    end else begin
                        dma_done_d  = 1'b1;
                        dma_rdata_d = bus.mem_ready ? acc_rdata : 32'd0;
                    end
                end
`ifdef DMARB_TIMEOUT_EN
                if (!bus.mem_ready) cnt_d = cnt_q + CW'(1);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_dma_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_dma_q  <= last_dma_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.err       = err_q;
    // Pipeline runs unless a CPU access is pending; released on cpu_done.
    assign bus.en        = ~bus.cpu_req | cpu_done_q;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter: self-checking bench for dm_port_arbiter. A memory
// responder with per-access programmable wait states serves the port; expected
// grant order, done cycles and read data come from a transaction-level model.
module tb_dm_port_arbiter;
    localparam int AW      = 7;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dm_port_arbiter_if #(.AW(AW)) bif ();
    dm_port_arbiter #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bif));

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [128];   // memory contents seen by the responder
    logic [31:0] ref_mem [128];   // model's view of memory contents
    int wait_q[$];                // wait states for upcoming accesses, in order
    int dflt_wait = 0;
    int cur_wait, wcnt;
    bit active;

    // Memory responder: assert mem_ready after the programmed number of waits.
    always @(negedge clk) begin
        if (!rst || !bif.mem_req) begin
            bif.mem_ready = 1'b0;
            active = 1'b0;
        end else if (!bif.mem_ready) begin
            if (!active) begin
                active = 1'b1;
                wcnt = 0;
                cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : dflt_wait;
            end
            if (wcnt == cur_wait) begin
                bif.mem_ready = 1'b1;
                bif.mem_rdata = bif.mem_we ? $urandom : mem_arr[bif.mem_addr];
                if (bif.mem_we) mem_arr[bif.mem_addr] = bif.mem_wdata;
            end else begin
                wcnt++;
            end
        end
    end

    task automatic set_req(input bit dma, input bit req, input bit we,
                           input logic [AW-1:0] a, input logic [31:0] d);
        if (dma) begin
            bif.dma_req = req; bif.dma_we = we; bif.dma_addr = a; bif.dma_wdata = d;
        end else begin
            bif.cpu_req = req; bif.cpu_we = we; bif.cpu_addr = a; bif.cpu_wdata = d;
        end
    endtask

    // Issue one access and observe it for up to 40 cycles (done_k=-1 if none).
    task automatic run_one(input bit dma, input bit we, input logic [AW-1:0] a,
                           input logic [31:0] d, input int w,
                           output int done_k, output int mreq_n, output int en_low,
                           output logic [31:0] rd, output logic er,
                           output logic cwe, output logic [AW-1:0] ca, output logic [31:0] cd);
        wait_q.push_back(w);
        @(negedge clk);
        set_req(dma, 1'b1, we, a, d);
        #1;
        en_low = (bif.en == 1'b0) ? 1 : 0;
        done_k = -1; mreq_n = 0; rd = '0; er = 1'b0; cwe = 1'b0; ca = '0; cd = '0;
        for (int k = 1; k <= 40 && done_k < 0; k++) begin
            @(negedge clk);
            if (bif.mem_req) begin
                if (mreq_n == 0) begin cwe = bif.mem_we; ca = bif.mem_addr; cd = bif.mem_wdata; end
                mreq_n++;
            end
            if (!bif.en) en_low++;
            if (dma ? bif.dma_done : bif.cpu_done) begin
                done_k = k;
                rd = dma ? bif.dma_rdata : bif.cpu_rdata;
                er = bif.err;
            end
        end
        set_req(dma, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        checks++; if (bif.mem_req !== 1'b0)   begin errors++; $display("FAIL reset_mem_req: got %b want 0", bif.mem_req); end
        checks++; if (bif.cpu_done !== 1'b0)  begin errors++; $display("FAIL reset_cpu_done: got %b want 0", bif.cpu_done); end
        checks++; if (bif.dma_done !== 1'b0)  begin errors++; $display("FAIL reset_dma_done: got %b want 0", bif.dma_done); end
        checks++; if (bif.err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b want 0", bif.err); end
        checks++; if (bif.en !== 1'b1)        begin errors++; $display("FAIL reset_en: got %b want 1", bif.en); end
        checks++; if (bif.cpu_rdata !== 32'd0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", bif.cpu_rdata); end
        checks++; if (bif.mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", bif.mem_addr); end
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bif.mem_req !== 1'b0)   begin errors++; $display("FAIL post_reset_idle: got mem_req %b want 0", bif.mem_req); end
        checks++; if (bif.cpu_done !== 1'b0)  begin errors++; $display("FAIL post_reset_done: got %b want 0", bif.cpu_done); end
    endtask

    task automatic test_single_read();
        int dk, mq, el; logic [31:0] rd, cd; logic er, cwe; logic [AW-1:0] ca;
        mem_arr[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        run_one(1'b0, 1'b0, 7'd5, 32'd0, 0, dk, mq, el, rd, er, cwe, ca, cd);
        checks++; if (dk != 2)  begin errors++; $display("FAIL read_done_cycle: got %0d want 2", dk); end
        checks++; if (mq != 1)  begin errors++; $display("FAIL read_mem_req_cycles: got %0d want 1", mq); end
        checks++; if (el != 2)  begin errors++; $display("FAIL read_en_low: got %0d want 2", el); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata: got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL read_err: got %b want 0", er); end
        checks++; if (ca !== 7'd5 || cwe !== 1'b0) begin errors++; $display("FAIL read_cmd: got addr %0d we %b want 5 0", ca, cwe); end
    endtask

    task automatic test_mem_wait();
        int dk, mq, el; logic [31:0] rd, cd; logic er, cwe; logic [AW-1:0] ca, a;
        a = AW'($urandom_range(0, 126));
        run_one(1'b0, 1'b0, a, 32'd0, 3, dk, mq, el, rd, er, cwe, ca, cd);
        checks++; if (dk != 5) begin errors++; $display("FAIL wait_done_cycle: got %0d want 5", dk); end
        checks++; if (mq != 4) begin errors++; $display("FAIL wait_mem_req_cycles: got %0d want 4", mq); end
        checks++; if (el != 5) begin errors++; $display("FAIL wait_en_low: got %0d want 5", el); end
        checks++; if (rd !== ref_mem[a]) begin errors++; $display("FAIL wait_rdata: got %h want %h", rd, ref_mem[a]); end
    endtask

    task automatic test_dma_write();
        int dk, mq, el; logic [31:0] rd, cd; logic er, cwe; logic [AW-1:0] ca;
        run_one(1'b1, 1'b1, 7'd127, 32'h1234, 0, dk, mq, el, rd, er, cwe, ca, cd);
        ref_mem[127] = 32'h1234;
        checks++; if (ca !== 7'd127) begin errors++; $display("FAIL dmaw_mem_addr: got %0d want 127", ca); end
        checks++; if (cd !== 32'h1234) begin errors++; $display("FAIL dmaw_mem_wdata: got %h want 1234", cd); end
        checks++; if (cwe !== 1'b1) begin errors++; $display("FAIL dmaw_mem_we: got %b want 1", cwe); end
        checks++; if (dk != 2) begin errors++; $display("FAIL dmaw_done_cycle: got %0d want 2", dk); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL dmaw_rdata: got %h want 0", rd); end
        checks++; if (el != 0) begin errors++; $display("FAIL dmaw_en_low: got %0d want 0", el); end
        run_one(1'b1, 1'b0, 7'd127, 32'd0, 1, dk, mq, el, rd, er, cwe, ca, cd);
        checks++; if (dk != 3) begin errors++; $display("FAIL dmar_done_cycle: got %0d want 3", dk); end
        checks++; if (rd !== ref_mem[127]) begin errors++; $display("FAIL dmar_rdata: got %h want %h", rd, ref_mem[127]); end
    endtask

    // Both requesters held high for n accesses; expect strict alternation
    // starting with the CPU, done at cumulative (2 + waits) cycles.
    task automatic test_back_to_back(input int n, input bit rnd);
        logic o_we [16]; logic [AW-1:0] o_a [16]; logic [31:0] o_d [16];
        int o_w [16]; int exp_k [16];
        int got = 0, ci = 0, di = 1, acc = 0;
        bit prev_req = 1'b0;
        logic [31:0] exp_rd, act_rd;
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        wait_q.delete();
        for (int i = 0; i < n; i++) begin
            o_we[i] = 1'($urandom_range(0, 1));
            o_a[i]  = AW'($urandom_range(0, 127));
            o_d[i]  = $urandom;
            o_w[i]  = rnd ? $urandom_range(0, 3) : 0;
            acc += 2 + o_w[i];
            exp_k[i] = acc;
            wait_q.push_back(o_w[i]);
        end
        @(negedge clk);
        set_req(1'b0, 1'b1, o_we[0], o_a[0], o_d[0]);
        set_req(1'b1, 1'b1, o_we[1], o_a[1], o_d[1]);
        for (int k = 1; k <= n * 8 + 20 && got < n; k++) begin
            @(negedge clk);
            if (bif.mem_req && !prev_req) begin
                checks++;
                if ({bif.mem_we, bif.mem_addr, bif.mem_wdata} !== {o_we[got], o_a[got], o_d[got]}) begin
                    errors++;
                    $display("FAIL b2b_cmd[%0d]: got we %b addr %0d data %h want we %b addr %0d data %h",
                             got, bif.mem_we, bif.mem_addr, bif.mem_wdata, o_we[got], o_a[got], o_d[got]);
                end
            end
            prev_req = bif.mem_req;
            checks++;
            if (bif.en !== (!bif.cpu_req || bif.cpu_done)) begin
                errors++;
                $display("FAIL b2b_en cycle %0d: got %b with cpu_req %b cpu_done %b", k, bif.en, bif.cpu_req, bif.cpu_done);
            end
            if (bif.cpu_done || bif.dma_done) begin
                exp_rd = o_we[got] ? 32'd0 : ref_mem[o_a[got]];
                if (o_we[got]) ref_mem[o_a[got]] = o_d[got];
                act_rd = bif.dma_done ? bif.dma_rdata : bif.cpu_rdata;
                checks++;
                if ({bif.cpu_done, bif.dma_done} !== ((got % 2 == 0) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL b2b_order[%0d]: got cpu_done %b dma_done %b want %s", got, bif.cpu_done, bif.dma_done, (got % 2 == 0) ? "cpu" : "dma");
                end
                checks++; if (k != exp_k[got]) begin errors++; $display("FAIL b2b_done_cycle[%0d]: got %0d want %0d", got, k, exp_k[got]); end
                checks++; if (act_rd !== exp_rd) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", got, act_rd, exp_rd); end
                got++;
                if (bif.cpu_done) begin
                    ci += 2;
                    if (ci < n) set_req(1'b0, 1'b1, o_we[ci], o_a[ci], o_d[ci]);
                    else        set_req(1'b0, 1'b0, 1'b0, '0, '0);
                end
                if (bif.dma_done) begin
                    di += 2;
                    if (di < n) set_req(1'b1, 1'b1, o_we[di], o_a[di], o_d[di]);
                    else        set_req(1'b1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        checks++; if (got != n) begin errors++; $display("FAIL b2b_count: got %0d accesses want %0d", got, n); end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        wait_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        bit seen = 1'b0;
        wait_q.push_back(3);
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b0, 7'd9, 32'd0);
        repeat (2) @(negedge clk);
        checks++; if (bif.mem_req !== 1'b1) begin errors++; $display("FAIL midrst_pending: got mem_req %b want 1", bif.mem_req); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bif.mem_req !== 1'b0) begin errors++; $display("FAIL midrst_async_drop: got mem_req %b want 0", bif.mem_req); end
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++; if (bif.en !== 1'b1) begin errors++; $display("FAIL midrst_en: got %b want 1", bif.en); end
        @(negedge clk) rst = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bif.cpu_done || bif.mem_req) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_done: got done/mem_req activity want none"); end
        wait_q.delete();
    endtask

    task automatic test_timeout();
        int dk, mq, el; logic [31:0] rd, cd; logic er, cwe; logic [AW-1:0] ca;
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        wait_q.delete();
        run_one(1'b0, 1'b0, 7'd33, 32'd0, 1000, dk, mq, el, rd, er, cwe, ca, cd);
`ifdef DMARB_TIMEOUT_EN
        checks++; if (dk != 16) begin errors++; $display("FAIL timeout_done_cycle: got %0d want 16", dk); end
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b want 1", er); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL timeout_rdata: got %h want 0", rd); end
`else
        checks++; if (dk != -1) begin errors++; $display("FAIL no_timeout_done: got done at %0d want none", dk); end
        checks++; if (mq != 40) begin errors++; $display("FAIL no_timeout_mem_req: got %0d cycles want 40", mq); end
`endif
        rst = 1'b0; @(negedge clk); rst = 1'b1;
        wait_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 128; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        test_reset();
        test_single_read();
        test_mem_wait();
        test_dma_write();
        test_back_to_back(6, 1'b0);
        test_back_to_back(12, 1'b1);
        test_reset_mid_wait();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
